// File: rtl/uart_wb_master_pkg.sv
// uart_wb_master_pkg
//   Shared definitions for the UART-to-Wishbone command bridge: FSM state
//   encoding, command opcodes, response bytes and response lengths.
package uart_wb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_WDATA   = 3'd3,
    ST_BUS     = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;

  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_BADCMD = 8'h3F;

  localparam logic [2:0] RSP_LEN_SINGLE = 3'd1;
  localparam logic [2:0] RSP_LEN_WORD   = 3'd4;

  // Single-byte responses are left-aligned so they leave the shifter first.
  function automatic logic [31:0] rsp_byte(input logic [7:0] b);
    return {b, 24'h0};
  endfunction

endpackage

// File: rtl/uart_wb_master_resp.sv
// uart_wb_master_resp
//   Loadable 4-byte response shifter. A load captures up to four bytes and a
//   byte count; bytes leave MSB first, one per tx_valid & tx_ready handshake.
//   tx_data/tx_valid are held stable while the transmitter stalls.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture load_data/load_cnt this cycle
//   load_data[31:0]     bytes to send, first byte in [31:24]
//   load_cnt[2:0]       number of bytes to send (1..4)
//   tx_ready            transmitter accepts tx_data
//   tx_data[7:0]        current response byte
//   tx_valid            tx_data valid
//   last                handshake of the final byte this cycle
module uart_wb_master_resp
  import uart_wb_master_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last
);

  logic [31:0] sr;
  logic [2:0]  rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      rem <= '0;
    end else if (load) begin
      sr  <= load_data;
      rem <= load_cnt;
    end else if (tx_valid && tx_ready) begin
      sr  <= {sr[23:0], 8'h00};
      rem <= rem - 3'd1;
    end
  end

  assign tx_valid = (rem != 3'd0);
  assign tx_data  = sr[31:24];
  assign last     = tx_valid & tx_ready & (rem == RSP_LEN_SINGLE);

endmodule

// File: rtl/uart_wb_master.sv
// uart_wb_master
//   Byte-stream command decoder and single-cycle Wishbone initiator.
//   Frames: 'W' adr_hi adr_lo d3 d2 d1 d0  -> write, replies 'K'
//           'R' adr_hi adr_lo              -> read, replies 4 data bytes
//           anything else                  -> replies '?'
//   Optional bus timeout: define UART_WB_MASTER_TIMEOUT_EN to abort a cycle
//   after TIMEOUT_CYCLES without ack_i and reply 'E'.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  command byte stream in
//   tx_data/tx_valid/tx_ready  response byte stream out
//   adr_o, dat_o, dat_i, we_o, sel_o, stb_o, cyc_o, ack_i   Wishbone master
module uart_wb_master
  import uart_wb_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i
);

  state_t      state, state_nx;
  logic        rdy_en;
  logic        req;
  logic [1:0]  wcnt;
  logic [15:0] adr_q;
  logic [31:0] dat_q;
  logic        we_q;
  logic        rx_fire;
  logic        bus_ack;
  logic        tmo;
  logic        rsp_load;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_cnt;
  logic        rsp_last;

  assign rx_fire = rx_valid & rx_ready;
  assign bus_ack = req & ack_i;

  // rdy_en keeps rx_ready low through reset and rises on the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign rx_ready = rdy_en & ((state == ST_IDLE) | (state == ST_ADDR_HI) |
                              (state == ST_ADDR_LO) | (state == ST_WDATA));

`ifdef UART_WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tcnt;

  // Held at zero outside BUS, so it starts from zero on every bus entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= '0;
    else if (state != ST_BUS)  tcnt <= '0;
    else if (!ack_i)           tcnt <= tcnt + TW'(1);
  end

  assign tmo = req & (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rsp_load = 1'b0;
    rsp_data = '0;
    rsp_cnt  = '0;
    case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            state_nx = ST_ADDR_HI;
          end else begin
            rsp_load = 1'b1;
            rsp_data = rsp_byte(RSP_BADCMD);
            rsp_cnt  = RSP_LEN_SINGLE;
            state_nx = ST_RESP;
          end
        end
      end
      ST_ADDR_HI: if (rx_fire) state_nx = ST_ADDR_LO;
      ST_ADDR_LO: if (rx_fire) state_nx = we_q ? ST_WDATA : ST_BUS;
      ST_WDATA:   if (rx_fire && wcnt == 2'd3) state_nx = ST_BUS;
      ST_BUS: begin
        // An ack in the same cycle as the timeout wins.
        if (bus_ack) begin
          rsp_load = 1'b1;
          rsp_data = we_q ? rsp_byte(RSP_OK) : dat_i;
          rsp_cnt  = we_q ? RSP_LEN_SINGLE : RSP_LEN_WORD;
          state_nx = ST_RESP;
        end else if (tmo) begin
          rsp_load = 1'b1;
          rsp_data = rsp_byte(RSP_ERR);
          rsp_cnt  = RSP_LEN_SINGLE;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: if (rsp_last) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Frame capture and bus request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
      wcnt  <= '0;
      req   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_fire && rx_data == CMD_WRITE) we_q <= 1'b1;
          if (rx_fire && rx_data == CMD_READ)  we_q <= 1'b0;
        end
        ST_ADDR_HI: if (rx_fire) adr_q[15:8] <= rx_data;
        ST_ADDR_LO: begin
          if (rx_fire) begin
            adr_q[7:0] <= rx_data;
            wcnt       <= '0;
            if (!we_q) req <= 1'b1;
          end
        end
        ST_WDATA: begin
          if (rx_fire) begin
            dat_q <= {dat_q[23:0], rx_data};
            wcnt  <= wcnt + 2'd1;
            if (wcnt == 2'd3) req <= 1'b1;
          end
        end
        ST_BUS: if (bus_ack || tmo) req <= 1'b0;
        default: ;
      endcase
    end
  end

  // Strobe drops in the ack cycle so a held strobe never re-triggers a slave.
  assign stb_o = req & ~ack_i;
  assign cyc_o = req & ~ack_i;
  assign sel_o = 4'hF;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign we_o  = we_q;

  uart_wb_master_resp u_resp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rsp_load),
    .load_data (rsp_data),
    .load_cnt  (rsp_cnt),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .last      (rsp_last)
  );

endmodule

// File: tb/tb_uart_wb_master.sv
module tb_uart_wb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic        cyc_o;
  logic        ack_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];

  // slave model controls and captures
  int          ack_delay = 0;
  bit          ack_en    = 1'b1;
  int          scnt      = 0;
  int          ack_cnt   = 0;
  logic        ack_prev  = 1'b0;
  logic [15:0] cap_adr;
  logic [31:0] cap_dat;
  logic        cap_we;

  uart_wb_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o),
    .sel_o(sel_o), .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Registered slave: acks after ack_delay+1 strobe cycles, one-cycle pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_i <= 1'b0;
      scnt  =  0;
    end else if (ack_i) begin
      ack_i <= 1'b0;
      scnt  =  0;
    end else if (stb_o && ack_en) begin
      if (scnt == ack_delay) begin
        ack_i   <= 1'b1;
        cap_adr <= adr_o;
        cap_dat <= dat_o;
        cap_we  <= we_o;
      end else begin
        scnt++;
      end
    end
  end

  // Monitor: scoreboard pop on tx handshakes, ack-cycle strobe check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack_prev) chk("tx_valid_after_ack", {31'd0, tx_valid}, 32'd1);
      if (ack_i) begin
        chk("stb_low_in_ack", {31'd0, stb_o}, 32'd0);
        ack_cnt++;
      end
      ack_prev = ack_i;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        else                   chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end else begin
      ack_prev = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    chk({tag, "_adr"},      {16'd0, adr_o},    32'd0);
    chk({tag, "_dat"},      dat_o,             32'd0);
    chk({tag, "_we"},       {31'd0, we_o},     32'd0);
    chk({tag, "_stb"},      {31'd0, stb_o},    32'd0);
    chk({tag, "_cyc"},      {31'd0, cyc_o},    32'd0);
    chk({tag, "_sel"},      {28'd0, sel_o},    32'hF);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    dat_i    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

    // Write frame, slave acks in the third strobe cycle
    ack_delay = 1; ack_cnt = 0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("wr_stb_rise", {31'd0, stb_o}, 32'd1);
    wait_drain();
    chk("wr_adr", {16'd0, cap_adr}, 32'h0010);
    chk("wr_dat", cap_dat, 32'hDEADBEEF);
    chk("wr_we", {31'd0, cap_we}, 32'd1);
    chk("wr_ack_count", ack_cnt, 1);
    chk("wr_adr_hold", {16'd0, adr_o}, 32'h0010);

    // Read frame, zero-wait slave
    ack_delay = 0; ack_cnt = 0;
    dat_i = 32'hCAFEF00D;
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    wait_drain();
    chk("rd_we", {31'd0, cap_we}, 32'd0);
    chk("rd_adr", {16'd0, cap_adr}, 32'h1234);
    chk("rd_ack_count", ack_cnt, 1);

    // Bad command, then a valid write
    ack_cnt = 0;
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    chk("bad_no_stb", {31'd0, stb_o}, 32'd0);
    wait_drain();
    chk("bad_no_ack", ack_cnt, 0);
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'hA5); send_byte(8'h5A);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    wait_drain();
    chk("wr2_adr", {16'd0, cap_adr}, 32'hA55A);
    chk("wr2_dat", cap_dat, 32'h01020304);

    // Transmitter stalls during a read response
    tx_ready = 1'b0;
    dat_i = 32'h11223344;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h20);
    n = 0;
    while (!tx_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_tx_data_stable", {24'd0, tx_data}, 32'h11);
      chk("bp_rx_ready_low", {31'd0, rx_ready}, 32'd0);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_drain();

`ifdef UART_WB_MASTER_TIMEOUT_EN
    // No ack: strobe for TIMEOUT_CYCLES cycles, then 'E'
    ack_en = 1'b0;
    exp_q.push_back(8'h45);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h40);
    n = 0;
    while (stb_o && n < 50) begin n++; @(posedge clk); #1; end
    chk("tmo_stb_cycles", n, 8);
    wait_drain();
    // Ack in the final cycle completes normally
    ack_en = 1'b1; ack_delay = 6; ack_cnt = 0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h44);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    wait_drain();
    chk("tmo_late_ack_count", ack_cnt, 1);
    ack_delay = 0;
`endif

    // Reset in the middle of a write frame
    send_byte(8'h57); send_byte(8'h00);
    rst_n = 1'b0;
    #2;
    check_reset_values("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dat_i = 32'h12345678; ack_cnt = 0;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD);
    wait_drain();
    chk("post_rst_adr", {16'd0, cap_adr}, 32'hABCD);
    chk("post_rst_we", {31'd0, cap_we}, 32'd0);
    chk("post_rst_ack_count", ack_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Byte-stream command decoder and Wishbone initiator. It accepts host command bytes from the UART receive path and issues single 32-bit Wishbone read/write cycles to the peripheral bus (UART, GPIO and the other slaves). It returns status/read-data bytes to the UART transmit path. It is the bus-master counterpart of the existing Wishbone slave peripherals and serves as the debug/boot access port.

## Interface
- TIMEOUT_CYCLES, 1024: bus cycles to wait for ack_i before aborting (used only with timeout feature).
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  command byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid & rx_ready
- tx_data  out  8  response byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte consumed when tx_valid & tx_ready
- adr_o  out  16  Wishbone address
- dat_o  out  32  Wishbone write data
- dat_i  in  32  Wishbone read data
- we_o  out  1  write enable
- sel_o  out  4  byte select, constant 4'hF
- stb_o  out  1  strobe
- cyc_o  out  1  cycle
- ack_i  in  1  acknowledge

## Operation
- Command frame: cmd byte, adr[15:8], adr[7:0], then for writes dat[31:24], dat[23:16], dat[15:8], dat[7:0]. All fields are MSB first.
- cmd 0x57 ('W') = write, responds 0x4B ('K').
- cmd 0x52 ('R') = read, responds 4 bytes of read data MSB first.
- Any other cmd byte: no bus cycle, responds 0x3F ('?'), returns to IDLE.
- States: IDLE → ADDR_HI → ADDR_LO → (write: WDATA, 4-byte counter) → BUS → RESP → IDLE.
- rx_ready=1 only in IDLE, ADDR_HI, ADDR_LO, WDATA. It is 0 in BUS and RESP, so no bytes are dropped (backpressure).
- BUS: internal request register req set; stb_o = cyc_o = req & ~ack_i, so the strobe is low during the ack cycle. This makes the bridge safe with slaves that emit single-cycle ack pulses and restart on a held strobe.
- On ack_i while req: capture dat_i (reads), clear req, enter RESP.
- RESP: response shift register plus byte count (1 or 4). tx_data/tx_valid hold stable while tx_valid & ~tx_ready. The last byte handshake returns the block to IDLE.
- adr_o, dat_o, we_o hold their values from capture until the next frame overwrites them.

## Timing
- Reset values: rx_ready=0 during reset, 1 from first clk after release; tx_valid=0, tx_data=0, adr_o=0, dat_o=0, we_o=0, stb_o=0, cyc_o=0, sel_o=4'hF; state IDLE.
- stb_o rises the cycle after the last frame byte is accepted.
- Zero-wait slave (ack in first strobe cycle): tx_valid rises the cycle after ack_i.
- One response byte per tx handshake; no bubble between consecutive bytes when tx_ready is held high.
- Reset asserted mid-frame or mid-bus cycle: immediate abort, all outputs to reset values, partial frame discarded.
- ack_i when req=0: ignored.

## Configuration
- UART_WB_MASTER_TIMEOUT_EN defined: a counter clears on entry to BUS and increments each BUS cycle without ack_i.
  - Count reaching TIMEOUT_CYCLES-1 with no ack: clear req, respond single byte 0x45 ('E') for both reads and writes.
  - ack_i on that same cycle wins and completes normally.
- Undefined: no counter; BUS waits indefinitely for ack_i.

## Structure
- Package uart_wb_master_pkg: state encoding; CMD_WRITE=8'h57, CMD_READ=8'h52; RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_BADCMD=8'h3F.
- One sub-module uart_wb_master_resp: loadable 4-byte response shift register with byte count and tx valid/ready handshake.

## Test plan
- Write frame 57 00 10 DE AD BE EF, slave acks after 3 cycles → adr_o=16'h0010, dat_o=32'hDEADBEEF, we_o=1, exactly one ack cycle with stb_o low in it, tx 4B.
- Read frame 52 12 34, slave returns 32'hCAFEF00D → we_o=0, tx CA FE F0 0D in order.
- Byte 0x00 in IDLE → no stb_o, tx 3F; following valid write frame executes normally.
- tx_ready held low 5 cycles during read response → tx_data stable, no byte lost or duplicated; rx_ready=0 throughout.
- With UART_WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack → stb_o high 8 cycles then low, tx 45. Ack on cycle 8 → normal response instead.
- rst_n pulsed after 2 bytes of a write frame → outputs at reset values; fresh read frame completes correctly.
